ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter inside cadr_core; the opposite direction to the existing PS/2 receive path.
- Sends command bytes to the emulated keyboard or mouse, e.g. LED set 0xED or enable-reporting 0xF4.
- Drives the open-drain-style ps2_*_clk_in/ps2_*_data_in lines back to hps_io and monitors the ps2_*_clk_out/ps2_*_data_out lines.
- One instance per device; all logic runs in clk_sys.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles between device clock falls, or from inhibit release to the first fall (20 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on ps2_clk_i and ps2_data_i (minimum 2).

Ports:
- clk, in, 1: clk_sys.
- reset, in, 1: synchronous, active-high.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: request; accepted when tx_valid & tx_ready.
- tx_ready, out, 1: high only in IDLE.
- ps2_clk_i, in, 1: device-driven clock (from hps_io ps2_*_clk_out).
- ps2_data_i, in, 1: device-driven data (from hps_io ps2_*_data_out).
- ps2_clk_o, out, 1: host clock drive; 0 = pull low, 1 = released (to hps_io ps2_*_clk_in).
- ps2_data_o, out, 1: host data drive; 0 = pull low, 1 = released.
- busy, out, 1: high whenever the state is not IDLE; lets the receiver ignore the frame.
- done, out, 1: one-cycle pulse on successful ACK.
- ack_err, out, 1: one-cycle pulse when the device does not ACK.
- timeout, out, 1: one-cycle pulse on timeout abort.

Behaviour:
- Reset values: ps2_clk_o=1, ps2_data_o=1, tx_ready=1, busy=0, done=0, ack_err=0, timeout=0; state IDLE.
- Reset mid-frame releases both lines on the next clk edge. No partial frame resumes.
- Inputs pass through SYNC_STAGES flops. A fall is sync_clk 1→0, detected SYNC_STAGES+1 cycles after the pin change.
- Line value is taken as the input AND the own drive; the block reads the inputs directly, since the device-side outputs reflect the bus.
- IDLE:
  - On tx_valid & tx_ready, latch tx_data into a shift register.
  - Compute parity = ~^tx_data (odd parity).
  - Set frame = {1'b1 stop, parity, data[7:0]}, LSB first.
  - Go to INHIBIT. tx_ready drops on the next cycle.
- INHIBIT: ps2_clk_o=0, ps2_data_o=1 for INHIBIT_CYCLES cycles.
- START:
  - First cycle: ps2_data_o=0 while ps2_clk_o is still 0.
  - Next cycle: ps2_clk_o=1 (released). Clear bit counter and watchdog.
- SHIFT:
  - On each fall n=1..10, drive frame bit n-1 within one cycle of detection.
  - Falls 1–8 carry data0..7, fall 9 carries parity, fall 10 carries stop (data_o=1).
  - After fall 10 go to ACK.
- ACK: on fall 11, sample sync_data.
  - 0: go to WAIT_IDLE.
  - 1: pulse ack_err, go to IDLE.
- WAIT_IDLE: wait until sync_clk=1 and sync_data=1 together, then pulse done and go to IDLE.
- Watchdog:
  - Counts in START, SHIFT, ACK and WAIT_IDLE; resets on every detected fall.
  - Reaching TIMEOUT_CYCLES-1: release both lines, pulse timeout, go to IDLE.
- A new tx_valid while busy is ignored because tx_ready=0. tx_data is only sampled at acceptance.
- The status pulses are mutually exclusive. tx_ready returns to 1 in the same cycle as the done, ack_err or timeout pulse.
- Counter widths come from $clog2 of the parameters.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - On ack_err or timeout, the latched byte is resent once automatically, re-entering INHIBIT.
  - The status pulse is raised only if the retry also fails. done is raised if the retry succeeds.
  - tx_ready stays 0 throughout.
- Undefined: no retry; the failure pulse is raised on the first attempt.

Decomposition:
- ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE);
  - localparam FRAME_BITS=10;
  - function odd_parity(logic [7:0]).
- One natural sub-module: ps2_edge_sync, an N-stage synchronizer plus fall detector, shared with the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → bits after start 1,0,1,1,0,1,1,1, parity 1, stop 1. Clock held low ≥5000 cycles first. done pulses once; tx_ready returns to 1.
- Send 0xF4 → parity 0. Send 0x00 → parity 1. Send 0xFF → parity 1. Checked at fall 9 each time.
- Device omits the ACK (data high at fall 11) → ack_err pulses and both lines are released. With RETRY_EN: exactly 2 inhibit periods are observed, then ack_err.
- Device stops clocking after fall 4 → timeout pulses TIMEOUT_CYCLES after the last fall, ps2_clk_o=ps2_data_o=1, and the state is IDLE.
- Assert reset at fall 6 → both lines read 1 on the next clk edge, tx_ready=1, and no done, ack_err or timeout pulse follows.
- Hold tx_valid with 0x55 during an active 0xED frame → only 0xED is transmitted. 0x55 is accepted in the cycle tx_ready rises.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length and parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Bits clocked out after the start bit: data[7:0], parity, stop.
    localparam int unsigned FRAME_BITS = 10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// N-stage synchronizer with registered falling-edge detect for a PS/2 line.
// Idle level is high, so all stages reset to 1 and no spurious fall follows reset.
module ps2_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic fall
);

    logic [STAGES-1:0] stg;
    logic              q_d;

    assign q = stg[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            stg  <= '1;
            q_d  <= 1'b1;
            fall <= 1'b0;
        end else begin
            stg  <= {stg[STAGES-2:0], d};
            q_d  <= stg[STAGES-1];
            fall <= q_d & ~stg[STAGES-1];
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// Optional PS2_HOST_TX_RETRY_EN resends the latched byte once on ack_err or timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INHIB_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_BITS + 1);

    ps2_state_e              state;
    logic [FRAME_BITS-1:0]   frame;
    logic [INHIB_W-1:0]      inhib_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic [CNT_W-1:0]        bit_cnt;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [7:0]              byte_q;
    logic                    retried;
`endif

    logic sync_clk;
    logic sync_data;
    logic clk_fall;
    logic data_fall_unused;

    logic wd_active_c;
    logic wd_expire_c;
    logic ack_fail_c;
    logic fail_c;

    ps2_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk  (clk),
        .reset(reset),
        .d    (ps2_clk_i),
        .q    (sync_clk),
        .fall (clk_fall)
    );

    ps2_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk  (clk),
        .reset(reset),
        .d    (ps2_data_i),
        .q    (sync_data),
        .fall (data_fall_unused)
    );

    // Abort conditions: watchdog expiry (a fall always wins) or missing ACK on fall 11.
    always_comb begin
        wd_active_c = 1'b0;
        wd_expire_c = 1'b0;
        ack_fail_c  = 1'b0;
        if ((state == START) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE)) begin
            wd_active_c = 1'b1;
        end
        if (wd_active_c && !clk_fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))) begin
            wd_expire_c = 1'b1;
        end
        if ((state == ACK) && clk_fall && sync_data) begin
            ack_fail_c = 1'b1;
        end
        fail_c = wd_expire_c | ack_fail_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame      <= '0;
            inhib_cnt  <= '0;
            wd_cnt     <= '0;
            bit_cnt    <= '0;
            ps2_clk_o  <= 1'b1;
            ps2_data_o <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            timeout    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            byte_q     <= '0;
            retried    <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;

            if (!wd_active_c || clk_fall) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (fail_c) begin
                ps2_clk_o  <= 1'b1;
                ps2_data_o <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                if (!retried) begin
                    retried   <= 1'b1;
                    frame     <= {1'b1, odd_parity(byte_q), byte_q};
                    inhib_cnt <= '0;
                    ps2_clk_o <= 1'b0;
                    state     <= INHIBIT;
                end else
`endif
                begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    ack_err  <= ack_fail_c;
                    timeout  <= wd_expire_c;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready) begin
                            frame      <= {1'b1, odd_parity(tx_data), tx_data};
                            inhib_cnt  <= '0;
                            ps2_clk_o  <= 1'b0;
                            ps2_data_o <= 1'b1;
                            tx_ready   <= 1'b0;
                            busy       <= 1'b1;
                            state      <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                            byte_q     <= tx_data;
                            retried    <= 1'b0;
`endif
                        end
                    end

                    INHIBIT: begin
                        if (inhib_cnt == INHIB_W'(INHIBIT_CYCLES - 1)) begin
                            ps2_data_o <= 1'b0;
                            state      <= START;
                        end else begin
                            inhib_cnt <= inhib_cnt + INHIB_W'(1);
                        end
                    end

                    // Data is already low; releasing clock hands clocking to the device.
                    START: begin
                        ps2_clk_o <= 1'b1;
                        bit_cnt   <= '0;
                        wd_cnt    <= '0;
                        state     <= SHIFT;
                    end

                    SHIFT: begin
                        if (clk_fall) begin
                            ps2_data_o <= frame[0];
                            frame      <= {1'b0, frame[FRAME_BITS-1:1]};
                            bit_cnt    <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                                state <= ACK;
                            end
                        end
                    end

                    ACK: begin
                        if (clk_fall) begin
                            state <= WAIT_IDLE;
                        end
                    end

                    WAIT_IDLE: begin
                        if (sync_clk && sync_data) begin
                            done     <= 1'b1;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end

                    default: begin
                        ps2_clk_o  <= 1'b1;
                        ps2_data_o <= 1'b1;
                        tx_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device driving a wired-AND bus.
module tb_ps2_host_tx;

    localparam int unsigned INHIB = 40;
    localparam int unsigned TMO   = 300;
    localparam int unsigned SYNC  = 2;
    localparam int          HALF  = 15;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int          ATTEMPTS = 2;
`else
    localparam int          ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_o, ps2_data_o;
    logic       busy, done, ack_err, timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0, n_ack = 0, n_tmo = 0, tmo_cyc = 0;

    assign ps2_clk_i  = dev_clk & ps2_clk_o;
    assign ps2_data_i = dev_data & ps2_data_o;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIB),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk_i (ps2_clk_i),
        .ps2_data_i(ps2_data_i),
        .ps2_clk_o (ps2_clk_o),
        .ps2_data_o(ps2_data_o),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done)    n_done++;
        if (ack_err) n_ack++;
        if (timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) check("accept_wait", 0, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) check(tag, 0, 1);
    endtask

    // Device side: observe inhibit and start, then clock 11 falls sampling the host's bits.
    task automatic dev_frame(input bit ack, input int stop_after, input int reset_at,
                             output logic [9:0] bits, output int inhib_len, output int last_fall);
        int k;
        bits      = '0;
        inhib_len = 0;
        last_fall = 0;
        k = 0;
        while (ps2_clk_i && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (ps2_clk_i) begin
            check("inhibit_wait", 0, 1);
            return;
        end
        while (!ps2_clk_i && ps2_data_i && k < 40000) begin
            inhib_len++;
            @(negedge clk);
            k++;
        end
        while (!ps2_clk_i && k < 40000) begin
            @(negedge clk);
            k++;
        end
        if (!ps2_clk_i || ps2_data_i) begin
            check("start_wait", 0, 1);
            return;
        end
        for (int n = 1; n <= 11; n++) begin
            if (n == 11 && ack) dev_data = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk   = 1'b0;
            last_fall = cyc;
            if (n == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (n <= 10) bits[n-1] = ps2_data_i;
            dev_clk = 1'b1;
            if (n == stop_after) return;
        end
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
    endtask

    logic [7:0] vec_byte [4] = '{8'hED, 8'hF4, 8'h00, 8'hFF};
    logic       vec_par  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [9:0] bits;
        int         ilen, lf, b_done, b_ack, b_tmo, inhibits, k;

        repeat (3) @(negedge clk);
        check("rst_clk_o", ps2_clk_o, 1);
        check("rst_data_o", ps2_data_o, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, ack_err, timeout}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Normal frames with ACK, including parity corners.
        for (int i = 0; i < 4; i++) begin
            b_done = n_done; b_ack = n_ack; b_tmo = n_tmo;
            fork
                send_byte(vec_byte[i]);
                dev_frame(1'b1, 0, 0, bits, ilen, lf);
            join
            wait_ready("ready_wait");
            @(negedge clk);
            check("data_bits", bits[7:0], vec_byte[i]);
            check("parity_bit", bits[8], vec_par[i]);
            check("stop_bit", bits[9], 1);
            check("inhibit_len", ilen >= INHIB, 1);
            check("done_once", n_done - b_done, 1);
            check("no_fail_pulse", (n_ack - b_ack) + (n_tmo - b_tmo), 0);
        end

        // Device withholds ACK.
        b_done = n_done; b_ack = n_ack; inhibits = 0;
        fork
            send_byte(8'hF4);
            for (int a = 0; a < ATTEMPTS; a++) begin
                dev_frame(1'b0, 0, 0, bits, ilen, lf);
                if (ilen > INHIB / 2) inhibits++;
            end
        join
        wait_ready("noack_ready");
        @(negedge clk);
        check("ack_err_once", n_ack - b_ack, 1);
        check("noack_no_done", n_done - b_done, 0);
        check("noack_release", {ps2_clk_o, ps2_data_o}, 2'b11);
        check("inhibit_periods", inhibits, ATTEMPTS);
        repeat (100) @(negedge clk);
        check("noack_stays_idle", {ps2_clk_o, busy}, 2'b10);

        // Device stops clocking after fall 4.
        b_tmo = n_tmo;
        fork
            send_byte(8'h0F);
            for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b1, 4, 0, bits, ilen, lf);
        join
        k = 0;
        while (n_tmo == b_tmo && k < int'(TMO) + 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("timeout_once", n_tmo - b_tmo, 1);
        check("timeout_delay", (tmo_cyc - lf >= int'(TMO)) && (tmo_cyc - lf <= int'(TMO + SYNC + 3)), 1);
        check("tmo_release", {ps2_clk_o, ps2_data_o}, 2'b11);
        check("tmo_idle", {tx_ready, busy}, 2'b10);

        // Reset asserted at fall 6.
        b_done = n_done; b_ack = n_ack; b_tmo = n_tmo;
        fork
            send_byte(8'hA5);
            dev_frame(1'b1, 0, 6, bits, ilen, lf);
        join
        check("rstmid_lines", {ps2_clk_o, ps2_data_o}, 2'b11);
        check("rstmid_ready", {tx_ready, busy}, 2'b10);
        reset = 1'b0;
        repeat (int'(TMO) + 50) @(negedge clk);
        check("rstmid_no_pulse", (n_done - b_done) + (n_ack - b_ack) + (n_tmo - b_tmo), 0);

        // tx_valid held through a frame with different data.
        b_done = n_done;
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h55;
        check("hold_accept", busy, 1);
        dev_frame(1'b1, 0, 0, bits, ilen, lf);
        check("hold_first", bits[7:0], 8'hED);
        wait_ready("hold_ready");
        @(negedge clk);
        check("hold_second_accept", {busy, tx_ready}, 2'b10);
        tx_valid = 1'b0;
        dev_frame(1'b1, 0, 0, bits, ilen, lf);
        check("hold_second", bits[7:0], 8'h55);
        wait_ready("hold_ready2");
        @(negedge clk);
        check("hold_done_twice", n_done - b_done, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_time_limit got 1 exp 0");
        $fatal(1);
    end

endmodule
